line_window_ctrl: RTL and testbench

- Upstream neighbour of the 3x3 convolution stage.
- Takes a raster pixel stream (8 bit/pixel, one row = IMG_WIDTH pixels) and stores it in four rotating line buffers.
- Emits 3x3 pixel windows as 72-bit words with a valid strobe, in the packed format the convolution stage consumes.
- Pulses an interrupt each time a row has been consumed, so the DMA/host can send another row.

---
 rtl/line_window_ctrl_pkg.sv | 22 ++
 rtl/line_window_ctrl_line_buffer.sv | 63 ++++++
 rtl/line_window_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_line_window_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/line_window_ctrl_pkg.sv
// Shared definitions for the 3x3 line-window front end.
//   PIX_W   : bits per pixel
//   WIN_PIX : pixels per window (3x3)
//   WIN_W   : packed window width handed to the convolution stage
//   state_e : read-side sequencer states
package line_window_ctrl_pkg;

  localparam int PIX_W   = 8;
  localparam int WIN_PIX = 9;
  localparam int WIN_W   = PIX_W * WIN_PIX;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    READING = 1'b1
  } state_e;

  // Ring index helper for the four rotating buffers (2-bit wrap).
  function automatic logic [1:0] ring_add(input logic [1:0] base, input logic [1:0] ofs);
    return base + ofs;
  endfunction

endpackage

// File: rtl/line_window_ctrl_line_buffer.sv
// One image row of pixel storage.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (pointers only)
//   wr_data     : pixel to store at the internal write column
//   wr_valid    : store wr_data and advance the write column (wraps at IMG_WIDTH-1)
//   rd_advance  : advance the read column (wraps after column IMG_WIDTH-3)
//   rd_data     : {pix[c+2], pix[c+1], pix[c]} at read column c, combinational
module line_buffer
  import line_window_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   wr_data,
  input  logic               wr_valid,
  input  logic               rd_advance,
  output logic [3*PIX_W-1:0] rd_data
);

  localparam int COL_W = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 2;
  localparam logic [COL_W-1:0] LAST_WR_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] LAST_RD_COL = COL_W'(IMG_WIDTH - 3);

  logic [PIX_W-1:0] mem_r [IMG_WIDTH];
  logic [COL_W-1:0] wr_ptr_r;
  logic [COL_W-1:0] rd_ptr_r;
  logic [COL_W-1:0] rd_ptr1_s;
  logic [COL_W-1:0] rd_ptr2_s;

  // Pixel storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_valid) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Write column: one step per stored pixel, wraps at the row end.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= COL_W'(0);
    end else if (wr_valid) begin
      wr_ptr_r <= (wr_ptr_r == LAST_WR_COL) ? COL_W'(0) : wr_ptr_r + COL_W'(1);
    end
  end

  // Read column: wraps after the last full 3-wide window so the next row starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= COL_W'(0);
    end else if (rd_advance) begin
      rd_ptr_r <= (rd_ptr_r == LAST_RD_COL) ? COL_W'(0) : rd_ptr_r + COL_W'(1);
    end
  end

  // Three adjacent pixels; rd_ptr_r never exceeds IMG_WIDTH-3 so c+2 stays in range.
  always_comb begin
    rd_ptr1_s = rd_ptr_r + COL_W'(1);
    rd_ptr2_s = rd_ptr_r + COL_W'(2);
    rd_data   = {mem_r[rd_ptr2_s], mem_r[rd_ptr1_s], mem_r[rd_ptr_r]};
  end

endmodule

// File: rtl/line_window_ctrl.sv
// Line-window controller feeding the 3x3 convolution stage.
// Collects a raster pixel stream into four rotating line buffers and emits
// 3x3 windows (72-bit, top row in the low bytes) once three rows are held.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_pixel_data        : incoming 8-bit pixel
//   i_pixel_data_valid  : pixel strobe, one pixel per cycle
//   o_pixel_data        : 3x3 window, holds its value while valid is low
//   o_pixel_data_valid  : window strobe
//   o_intr              : one-cycle pulse after each row has been consumed
//   o_overflow          : sticky, a pixel was dropped because all buffers were full
module line_window_ctrl
  import line_window_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  parameter int NUM_LBUF  = 4     // fixed; buffer indices are 2-bit ring counters
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] i_pixel_data,
  input  logic             i_pixel_data_valid,
  output logic [WIN_W-1:0] o_pixel_data,
  output logic             o_pixel_data_valid,
  output logic             o_intr,
  output logic             o_overflow
);

  localparam int COL_W = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 2;
  localparam int CNT_W = $clog2(NUM_LBUF * IMG_WIDTH + 1);
  localparam logic [COL_W-1:0] LAST_WR_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] LAST_RD_COL = COL_W'(IMG_WIDTH - 3);
  localparam logic [CNT_W-1:0] ROW_PIX     = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] READ_LVL    = CNT_W'(3 * IMG_WIDTH);
  localparam logic [CNT_W-1:0] FULL_LVL    = CNT_W'(NUM_LBUF * IMG_WIDTH);

  state_e             state_r;
  state_e             state_s;
  logic [1:0]         wr_buf_r;
  logic [1:0]         rd_buf_r;
  logic [1:0]         mid_buf_s;
  logic [1:0]         bot_buf_s;
  logic [COL_W-1:0]   wr_col_r;
  logic [COL_W-1:0]   rd_col_r;
  logic [CNT_W-1:0]   pix_cnt_r;
  logic [CNT_W-1:0]   pix_cnt_s;
  logic               row_done_s;
  logic               row_done_r;
  logic               wr_accept_s;
  logic               rd_advance_s;
  logic [3:0]         wr_en_s;
  logic [3*PIX_W-1:0] lb_rd_s [4];
  logic [WIN_W-1:0]   window_s;

  // Row read completes on the cycle the last window column is registered.
  always_comb begin
    row_done_s = (state_r == READING) && (rd_col_r == LAST_RD_COL);
  end

  // A pixel is accepted unless every buffer is full; a row finishing in the
  // same cycle frees a buffer, so the write is taken then.
  always_comb begin
    wr_accept_s = i_pixel_data_valid && ((pix_cnt_r != FULL_LVL) || row_done_s);
  end

  // Fill level next value: net effect of a write and a row release.
  always_comb begin
    pix_cnt_s = pix_cnt_r;
    if (wr_accept_s) begin
      pix_cnt_s = pix_cnt_s + CNT_W'(1);
    end else begin
      pix_cnt_s = pix_cnt_s;
    end
    if (row_done_s) begin
      pix_cnt_s = pix_cnt_s - ROW_PIX;
    end else begin
      pix_cnt_s = pix_cnt_s;
    end
  end

  // Route the write strobe to the buffer currently being filled.
  always_comb begin
    wr_en_s = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      wr_en_s[b] = wr_accept_s && (wr_buf_r == 2'(b));
    end
  end

  // Sequencer next state; all buffers step their read column together.
  always_comb begin
    state_s      = state_r;
    rd_advance_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pix_cnt_r >= READ_LVL) begin
          state_s = READING;
        end else begin
          state_s = IDLE;
        end
      end
      READING: begin
        rd_advance_s = 1'b1;
        if (row_done_s) begin
          state_s = IDLE;
        end else begin
          state_s = READING;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Assemble the window: top row = rd_buf, then the next two buffers in the ring.
  always_comb begin
    mid_buf_s = ring_add(rd_buf_r, 2'd1);
    bot_buf_s = ring_add(rd_buf_r, 2'd2);
    window_s  = {lb_rd_s[bot_buf_s], lb_rd_s[mid_buf_s], lb_rd_s[rd_buf_r]};
  end

  for (genvar g = 0; g < 4; g++) begin : g_lbuf
    line_buffer #(
      .IMG_WIDTH (IMG_WIDTH)
    ) u_lbuf (
      .clk        (clk),
      .rst        (rst),
      .wr_data    (i_pixel_data),
      .wr_valid   (wr_en_s[g]),
      .rd_advance (rd_advance_s),
      .rd_data    (lb_rd_s[g])
    );
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Write position: column within the row and which buffer receives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_col_r <= COL_W'(0);
      wr_buf_r <= 2'd0;
    end else if (wr_accept_s) begin
      if (wr_col_r == LAST_WR_COL) begin
        wr_col_r <= COL_W'(0);
        wr_buf_r <= ring_add(wr_buf_r, 2'd1);
      end else begin
        wr_col_r <= wr_col_r + COL_W'(1);
      end
    end
  end

  // Read position: column restarts on every entry to READING, top buffer rotates per row.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_col_r <= COL_W'(0);
      rd_buf_r <= 2'd0;
    end else if (state_r == READING) begin
      rd_col_r <= row_done_s ? COL_W'(0) : rd_col_r + COL_W'(1);
      if (row_done_s) begin
        rd_buf_r <= ring_add(rd_buf_r, 2'd1);
      end
    end else begin
      rd_col_r <= COL_W'(0);
    end
  end

  // Fill level register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt_r <= CNT_W'(0);
    end else begin
      pix_cnt_r <= pix_cnt_s;
    end
  end

  // Sticky overflow on any dropped pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_overflow <= 1'b0;
    end else if (i_pixel_data_valid && !wr_accept_s) begin
      o_overflow <= 1'b1;
    end
  end

  // Window output register; data holds while no window is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pixel_data       <= {WIN_W{1'b0}};
      o_pixel_data_valid <= 1'b0;
    end else if (state_r == READING) begin
      o_pixel_data       <= window_s;
      o_pixel_data_valid <= 1'b1;
    end else begin
      o_pixel_data_valid <= 1'b0;
    end
  end

  // Row-consumed pulse lands in the cycle after the last window is on the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_done_r <= 1'b0;
      o_intr     <= 1'b0;
    end else begin
      row_done_r <= row_done_s;
      o_intr     <= row_done_r;
    end
  end

endmodule

// File: tb/tb_line_window_ctrl.sv
// Self-checking bench for line_window_ctrl (IMG_WIDTH = 8).
// Reference model: the accepted pixel stream is kept in a queue; read row r
// must produce, for c = 0..W-3, the window built from stream rows r, r+1, r+2.
module tb_line_window_ctrl;
  import line_window_ctrl_pkg::*;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_pixel_data = 8'd0;
  logic        i_pixel_data_valid = 1'b0;
  logic [71:0] o_pixel_data;
  logic        o_pixel_data_valid;
  logic        o_intr;
  logic        o_overflow;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  stream_q [$];
  int          rd_row = 0;
  int          rd_c = 0;
  int          win_total = 0;
  int          intr_cnt = 0;
  int          cyc = 0;
  logic [71:0] first_win [16];
  int          first_cyc [16];
  int          last_cyc [16];

  always #5 clk = ~clk;

  line_window_ctrl #(.IMG_WIDTH(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_pixel_data       (i_pixel_data),
    .i_pixel_data_valid (i_pixel_data_valid),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_data_valid (o_pixel_data_valid),
    .o_intr             (o_intr),
    .o_overflow         (o_overflow)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Window whose rows start at pixel values t, m, b (each row three consecutive values).
  function automatic logic [71:0] pack_rows(input int t, input int m, input int b);
    logic [71:0] w;
    w = '0;
    for (int j = 0; j < 3; j++) begin
      w[j*8 +: 8]      = 8'(t + j);
      w[24 + j*8 +: 8] = 8'(m + j);
      w[48 + j*8 +: 8] = 8'(b + j);
    end
    return w;
  endfunction

  function automatic logic [71:0] exp_window(input int row, input int c);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 3; j++)
        w[(r*3 + j)*8 +: 8] = stream_q[(row + r)*W + c + j];
    return w;
  endfunction

  // Output monitor: every window is compared against the stream model.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (o_intr) intr_cnt++;
    if (o_pixel_data_valid) begin
      if (stream_q.size() < (rd_row + 3)*W) begin
        check("window_ready", 72'(stream_q.size()), 72'((rd_row + 3)*W));
      end else begin
        check("window", o_pixel_data, exp_window(rd_row, rd_c));
      end
      if (rd_row < 16) begin
        if (rd_c == 0) begin
          first_win[rd_row] = o_pixel_data;
          first_cyc[rd_row] = cyc;
        end
        if (rd_c == W-3) last_cyc[rd_row] = cyc;
      end
      win_total++;
      if (rd_c == W-3) begin
        rd_c = 0;
        rd_row++;
      end else begin
        rd_c++;
      end
    end
  end

  task automatic model_clear();
    stream_q.delete();
    rd_row = 0;
    rd_c = 0;
    win_total = 0;
    intr_cnt = 0;
  endtask

  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    i_pixel_data = v;
    i_pixel_data_valid = 1'b1;
    stream_q.push_back(v);
  endtask

  task automatic gap();
    @(negedge clk);
    i_pixel_data = 8'($urandom);
    i_pixel_data_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    i_pixel_data = 8'($urandom);
    i_pixel_data_valid = 1'($urandom);
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      i_pixel_data = 8'($urandom);
      i_pixel_data_valid = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    i_pixel_data_valid = 1'b0;
  endtask

  task automatic wait_rows(input int rows, input int budget);
    int t;
    t = 0;
    while (rd_row < rows && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("rows_done", 72'(rd_row), 72'(rows));
  endtask

  initial begin
    // Reset with random inputs.
    do_reset(3);
    check("rst_data", o_pixel_data, 72'd0);
    check("rst_valid", 72'(o_pixel_data_valid), 72'd0);
    check("rst_intr", 72'(o_intr), 72'd0);
    check("rst_ovf", 72'(o_overflow), 72'd0);

    // First three rows back-to-back: latency, burst shape, interrupt.
    for (int i = 0; i < 24; i++) drive(8'(i));
    gap();
    check("lat_edge1", 72'(o_pixel_data_valid), 72'd0);
    @(negedge clk);
    check("lat_edge2", 72'(o_pixel_data_valid), 72'd0);
    @(negedge clk);
    check("lat_rise", 72'(o_pixel_data_valid), 72'd1);
    check("first_win", o_pixel_data, pack_rows(0, 8, 16));
    for (int k = 1; k < W-2; k++) begin
      @(negedge clk);
      check("burst_valid", 72'(o_pixel_data_valid), 72'd1);
    end
    check("last_win", o_pixel_data, pack_rows(5, 13, 21));
    @(negedge clk);
    check("post_valid", 72'(o_pixel_data_valid), 72'd0);
    check("intr_pulse", 72'(o_intr), 72'd1);
    check("pix_cnt", 72'(dut.pix_cnt_r), 72'd16);
    @(negedge clk);
    check("intr_single", 72'(o_intr), 72'd0);
    check("intr_cnt1", 72'(intr_cnt), 72'd1);

    // Continuous 48 pixels: concurrent write/read and buffer wrap.
    do_reset(2);
    for (int i = 0; i < 48; i++) drive(8'(i));
    gap();
    wait_rows(4, 200);
    repeat (3) @(negedge clk);
    check("intr_cnt4", 72'(intr_cnt), 72'd4);
    check("burst2_first", first_win[1], pack_rows(8, 16, 24));
    check("wrap_first", first_win[3], pack_rows(24, 32, 40));
    check("burst2_gap_ok", 72'((first_cyc[1] - last_cyc[0]) <= 3), 72'd1);
    check("no_ovf_cont", 72'(o_overflow), 72'd0);

    // Reset during the third window, then a fresh image.
    do_reset(1);
    for (int i = 0; i < 24; i++) drive(8'(i));
    gap();
    repeat (4) @(negedge clk);
    check("third_win_live", 72'(o_pixel_data_valid), 72'd1);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 72'(o_pixel_data_valid), 72'd0);
    for (int i = 0; i < 24; i++) drive(8'(100 + i));
    gap();
    wait_rows(1, 100);
    repeat (3) @(negedge clk);
    check("post_rst_first", first_win[0], pack_rows(100, 108, 116));
    check("post_rst_intr", 72'(intr_cnt), 72'd1);

    // Random data with random input gaps.
    do_reset(2);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) gap();
      drive(8'($urandom));
    end
    gap();
    wait_rows(8, 600);
    repeat (3) @(negedge clk);
    check("rand_intr", 72'(intr_cnt), 72'd8);
    check("rand_windows", 72'(win_total), 72'd48);
    check("rand_no_ovf", 72'(o_overflow), 72'd0);

    // Overflow: hold the reader idle, fill all four buffers, then one more.
    do_reset(2);
    force dut.state_r = IDLE;
    for (int i = 0; i < 4*W; i++) drive(8'(i));
    gap();
    check("full_no_ovf", 72'(o_overflow), 72'd0);
    check("full_cnt", 72'(dut.pix_cnt_r), 72'(4*W));
    drive(8'hAA);
    gap();
    check("ovf_set", 72'(o_overflow), 72'd1);
    repeat (4) @(negedge clk);
    drive(8'h55);
    gap();
    check("ovf_sticky", 72'(o_overflow), 72'd1);
    check("ovf_cnt_held", 72'(dut.pix_cnt_r), 72'(4*W));
    rst = 1'b1;
    release dut.state_r;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    check("ovf_cleared", 72'(o_overflow), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
